// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC point-multiplication controller.
// Holds the FSM state encoding, mode encodings and the registered control-output bundle.
package ecc_pkg;

    localparam int   ECC_KEY_W       = 233;
    localparam logic MODE_DBL_ADD    = 1'b0;
    localparam logic MODE_ALWAYS_ADD = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        INIT,
        DBL_REQ,
        DBL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        NEXT,
        FINISH
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic key_zero;
        logic acc_load_base;
        logic dbl_in_valid;
        logic acc_load_dbl;
        logic add_in_valid;
        logic acc_load_add;
        logic dummy_load;
    } ctrl_out_t;

endpackage

// File: rtl/ecc_key_scanner.sv
// Scalar register and bit-index counter for the left-to-right key scan.
// Presents the currently indexed key bit plus index-zero and key-zero flags to the FSM.
module ecc_key_scanner
    import ecc_pkg::*;
#(
    parameter int KEY_W = ECC_KEY_W,
    parameter int CNT_W = $clog2(KEY_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [KEY_W-1:0] i_key,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_cur_bit,
    output logic             o_idx_zero,
    output logic             o_key_zero
);

    localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(KEY_W - 1);

    logic [KEY_W-1:0] r_key;
    logic [CNT_W-1:0] r_idx;

    // NOTE: non-blocking assignments make every register here sample pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_key <= i_key;
            r_idx <= IDX_TOP;
        end else if (i_dec && (r_idx != '0)) begin
            r_idx <= r_idx - 1'b1;
        end
    end

    assign o_idx      = r_idx;
    assign o_cur_bit  = r_key[r_idx];
    assign o_idx_zero = (r_idx == '0);
    assign o_key_zero = (r_key == '0);

endmodule

// File: rtl/ecc_pointmult_ctrl.sv
// Double-and-add control FSM for Q = k*P, scanning the key MSB first.
// Drives datapath load/valid pulses only; every output is registered.
module ecc_pointmult_ctrl
    import ecc_pkg::*;
#(
    parameter int KEY_W = ECC_KEY_W,
    parameter int CNT_W = $clog2(KEY_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [KEY_W-1:0] i_key,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_key_zero,
    output logic [CNT_W-1:0] o_bit_idx,
    output logic             o_acc_load_base,
    output logic             o_dbl_in_valid,
    input  logic             i_dbl_out_valid,
    output logic             o_acc_load_dbl,
    output logic             o_add_in_valid,
    input  logic             i_add_out_valid,
    output logic             o_acc_load_add,
    output logic             o_dummy_load
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_mode;
    logic             w_load;
    logic             w_dec;
    logic [CNT_W-1:0] w_idx;
    logic             w_cur_bit;
    logic             w_idx_zero;
    logic             w_key_zero;
    ctrl_out_t        w_out;
    ctrl_out_t        r_out;
    logic [CNT_W-1:0] r_bit_idx;

    ecc_key_scanner #(
        .KEY_W(KEY_W),
        .CNT_W(CNT_W)
    ) u_scanner (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_load),
        .i_dec     (w_dec),
        .i_key     (i_key),
        .o_idx     (w_idx),
        .o_cur_bit (w_cur_bit),
        .o_idx_zero(w_idx_zero),
        .o_key_zero(w_key_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_mode  <= MODE_DBL_ADD;
        end else begin
            r_state <= w_next_state;
            if (w_load) r_mode <= i_mode;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            IDLE: if (i_start) begin
                w_next_state = SCAN;
                w_load       = 1'b1;
            end
            SCAN: begin
                if (w_cur_bit)       w_next_state = INIT;
                else if (w_idx_zero) w_next_state = FINISH;
                else                 w_dec        = 1'b1;
            end
            INIT, NEXT: begin
                if (w_idx_zero) begin
                    w_next_state = FINISH;
                end else begin
                    w_dec        = 1'b1;
                    w_next_state = DBL_REQ;
                end
            end
            DBL_REQ:  w_next_state = DBL_WAIT;
            DBL_WAIT: if (i_dbl_out_valid) begin
                w_next_state = (w_cur_bit || (r_mode == MODE_ALWAYS_ADD)) ? ADD_REQ : NEXT;
            end
            ADD_REQ:  w_next_state = ADD_WAIT;
            ADD_WAIT: if (i_add_out_valid) w_next_state = NEXT;
            FINISH:   w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Handshake responses only count in their own WAIT state; strays elsewhere fall through.
    always_comb begin
        w_out               = '0;
        w_out.busy          = (r_state != IDLE);
        w_out.done          = (r_state == FINISH);
        w_out.acc_load_base = (r_state == INIT);
        w_out.dbl_in_valid  = (r_state == DBL_REQ);
        w_out.add_in_valid  = (r_state == ADD_REQ);
        w_out.acc_load_dbl  = (r_state == DBL_WAIT) && i_dbl_out_valid;
        w_out.acc_load_add  = (r_state == ADD_WAIT) && i_add_out_valid && w_cur_bit;
        w_out.dummy_load    = (r_state == ADD_WAIT) && i_add_out_valid && !w_cur_bit;
        if (w_load)
            w_out.key_zero = 1'b0;
        else if ((r_state == SCAN) && (w_next_state == FINISH))
            w_out.key_zero = w_key_zero;
        else
            w_out.key_zero = r_out.key_zero;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out     <= '0;
            r_bit_idx <= '0;
        end else begin
            r_out     <= w_out;
            r_bit_idx <= w_idx;
        end
    end

    assign o_busy          = r_out.busy;
    assign o_done          = r_out.done;
    assign o_key_zero      = r_out.key_zero;
    assign o_bit_idx       = r_bit_idx;
    assign o_acc_load_base = r_out.acc_load_base;
    assign o_dbl_in_valid  = r_out.dbl_in_valid;
    assign o_acc_load_dbl  = r_out.acc_load_dbl;
    assign o_add_in_valid  = r_out.add_in_valid;
    assign o_acc_load_add  = r_out.acc_load_add;
    assign o_dummy_load    = r_out.dummy_load;

endmodule

// File: tb/tb_ecc_pointmult_ctrl.sv
// Self-checking bench for ecc_pointmult_ctrl at KEY_W=8 with auto-responding doubler/adder models.
// Expected control events are queued from a double-and-add model and popped as the DUT pulses.
module tb_ecc_pointmult_ctrl;

    localparam int KEY_W = 8;
    localparam int CNT_W = $clog2(KEY_W);

    localparam int EV_BASE   = 1;
    localparam int EV_DBL_IN = 2;
    localparam int EV_LD_DBL = 3;
    localparam int EV_ADD_IN = 4;
    localparam int EV_LD_ADD = 5;
    localparam int EV_DUMMY  = 6;
    localparam int EV_DONE   = 7;

    typedef struct {
        int base;
        int dbl;
        int ld_dbl;
        int add;
        int ld_add;
        int dummy;
        int done;
    } counts_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             mode  = 1'b0;
    logic [KEY_W-1:0] key   = '0;
    logic             busy, done, key_zero;
    logic [CNT_W-1:0] bit_idx;
    logic             acc_load_base, dbl_in_valid, acc_load_dbl;
    logic             add_in_valid, acc_load_add, dummy_load;
    logic             dbl_out_valid, add_out_valid;
    logic             resp_dbl = 1'b0, resp_add = 1'b0;
    logic             man_dbl  = 1'b0, man_add  = 1'b0;
    logic             add_auto = 1'b1;

    assign dbl_out_valid = resp_dbl | man_dbl;
    assign add_out_valid = resp_add | man_add;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      sb[$];
    counts_t cnt  = '{default: 0};
    counts_t snap = '{default: 0};
    int      base_cyc, base_idx, dummy_idx, start_cyc, done_cyc;
    int      dbl_cyc[KEY_W];
    int      add_cyc[KEY_W];
    int      exp_t, exp_dbl, exp_add, exp_dummy;

    ecc_pointmult_ctrl #(
        .KEY_W(KEY_W),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_mode         (mode),
        .i_key          (key),
        .o_busy         (busy),
        .o_done         (done),
        .o_key_zero     (key_zero),
        .o_bit_idx      (bit_idx),
        .o_acc_load_base(acc_load_base),
        .o_dbl_in_valid (dbl_in_valid),
        .i_dbl_out_valid(dbl_out_valid),
        .o_acc_load_dbl (acc_load_dbl),
        .o_add_in_valid (add_in_valid),
        .i_add_out_valid(add_out_valid),
        .o_acc_load_add (acc_load_add),
        .o_dummy_load   (dummy_load)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, key_zero, acc_load_base, dbl_in_valid, acc_load_dbl,
                    add_in_valid, acc_load_add, dummy_load, bit_idx});
    endfunction

    task automatic observe(input int kind);
        int ev;
        int e;
        ev = kind * 256 + int'(bit_idx);
        if (sb.size() == 0) begin
            check("sb_unexpected", ev, 0);
        end else begin
            e = sb.pop_front();
            check("sb_event", ev, e);
        end
    endtask

    // Monitor: every control pulse is matched against the next queued expectation.
    initial forever begin
        @(negedge clk);
        if (acc_load_base) begin
            observe(EV_BASE); cnt.base++; base_cyc = cyc; base_idx = int'(bit_idx);
        end
        if (dbl_in_valid) begin
            observe(EV_DBL_IN); cnt.dbl++; dbl_cyc[bit_idx] = cyc;
        end
        if (acc_load_dbl) begin
            observe(EV_LD_DBL); cnt.ld_dbl++;
        end
        if (add_in_valid) begin
            observe(EV_ADD_IN); cnt.add++; add_cyc[bit_idx] = cyc;
        end
        if (acc_load_add) begin
            observe(EV_LD_ADD); cnt.ld_add++;
        end
        if (dummy_load) begin
            observe(EV_DUMMY); cnt.dummy++; dummy_idx = int'(bit_idx);
        end
        if (done) begin
            observe(EV_DONE); cnt.done++;
        end
    end

    // Doubler and adder models: result valid two cycles after the request cycle.
    initial forever begin
        @(negedge clk);
        if (dbl_in_valid) begin
            repeat (2) @(negedge clk);
            resp_dbl = 1'b1;
            @(negedge clk);
            resp_dbl = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (add_in_valid && add_auto) begin
            repeat (2) @(negedge clk);
            resp_add = 1'b1;
            @(negedge clk);
            resp_add = 1'b0;
        end
    end

    task automatic push_model(input logic [KEY_W-1:0] k, input logic m);
        exp_t = -1;
        for (int i = KEY_W - 1; i >= 0; i--)
            if (k[i] && exp_t < 0) exp_t = i;
        if (exp_t < 0) begin
            exp_dbl = 0; exp_add = 0; exp_dummy = 0;
            sb.push_back(EV_DONE * 256);
        end else begin
            exp_dbl   = exp_t;
            exp_add   = m ? exp_t : ($countones(k) - 1);
            exp_dummy = m ? (exp_t - ($countones(k) - 1)) : 0;
            sb.push_back(EV_BASE * 256 + exp_t);
            for (int i = exp_t - 1; i >= 0; i--) begin
                sb.push_back(EV_DBL_IN * 256 + i);
                sb.push_back(EV_LD_DBL * 256 + i);
                if (k[i] || m) begin
                    sb.push_back(EV_ADD_IN * 256 + i);
                    sb.push_back((k[i] ? EV_LD_ADD : EV_DUMMY) * 256 + i);
                end
            end
            sb.push_back(EV_DONE * 256);
        end
    endtask

    task automatic start_op(input logic [KEY_W-1:0] k, input logic m);
        push_model(k, m);
        @(negedge clk);
        snap      = cnt;
        key       = k;
        mode      = m;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        key   = KEY_W'($urandom);
        mode  = ~m;
    endtask

    task automatic finish_op(input logic exp_kz);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 400) begin
            @(negedge clk);
            waited++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        done_cyc = cyc;
        check("key_zero", 32'(key_zero), 32'(exp_kz));
        @(negedge clk);
        check("busy_after_done", 32'(busy), 0);
        check("key_zero_held", 32'(key_zero), 32'(exp_kz));
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic check_counts();
        check("n_base",   cnt.base - snap.base, (exp_t >= 0) ? 1 : 0);
        check("n_dbl",    cnt.dbl - snap.dbl, exp_dbl);
        check("n_ld_dbl", cnt.ld_dbl - snap.ld_dbl, exp_dbl);
        check("n_add",    cnt.add - snap.add, exp_add);
        check("n_ld_add", cnt.ld_add - snap.ld_add, exp_add - exp_dummy);
        check("n_dummy",  cnt.dummy - snap.dummy, exp_dummy);
        check("n_done",   cnt.done - snap.done, 1);
    endtask

    task automatic wait_pulse(input bit want_add, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (want_add ? add_in_valid : dbl_in_valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        // k = 0x0B, double-and-add
        start_op(8'h0B, 1'b0);
        finish_op(1'b0);
        check_counts();
        check("base_idx", base_idx, 3);
        check("base_cycle", base_cyc - start_cyc, KEY_W - 3 + 2);

        // k = 0x0B, always-add
        start_op(8'h0B, 1'b1);
        finish_op(1'b0);
        check_counts();
        check("dummy_idx", dummy_idx, 2);
        check("add_spacing_b0_b1", add_cyc[2] - dbl_cyc[2], add_cyc[1] - dbl_cyc[1]);
        check("add_spacing_b1_b1", add_cyc[0] - dbl_cyc[0], add_cyc[1] - dbl_cyc[1]);

        // zero key
        start_op(8'h00, 1'b0);
        finish_op(1'b1);
        check_counts();
        check("zero_done_cycle", done_cyc - start_cyc, KEY_W + 2);

        start_op(8'h01, 1'b0);
        finish_op(1'b0);
        check_counts();

        start_op(8'h80, 1'b0);
        finish_op(1'b0);
        check_counts();

        for (int n = 0; n < 6; n++) begin
            logic [KEY_W-1:0] rk;
            logic             rm;
            rk = KEY_W'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            start_op(rk, rm);
            finish_op(rk == '0);
            check_counts();
        end

        // START and stray adder valid while waiting on the doubler
        start_op(8'h0B, 1'b0);
        wait_pulse(1'b0, "stray_wait_dbl");
        @(negedge clk);
        start   = 1'b1;
        key     = 8'hFF;
        mode    = 1'b1;
        man_add = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        man_add = 1'b0;
        check("busy_during_wait", 32'(busy), 1);
        finish_op(1'b0);
        check_counts();

        // reset while waiting on the adder, then a late adder valid
        add_auto = 1'b0;
        start_op(8'h0B, 1'b0);
        wait_pulse(1'b1, "rst_wait_add");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outs", all_outs(), 0);
        sb.delete();
        man_add = 1'b1;
        @(negedge clk);
        man_add = 1'b0;
        check("late_valid_outs", all_outs(), 0);
        @(negedge clk);
        check("late_valid_outs2", all_outs(), 0);
        add_auto = 1'b1;

        start_op(8'h0B, 1'b1);
        finish_op(1'b0);
        check_counts();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
